// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - memory-stage load/store unit driving the dcache request/response handshake
module lsu_mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int WAIT_LIMIT = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_memread,
    input  logic                  i_memwrite,
    input  logic                  i_ls_b,
    input  logic                  i_ls_h,
    input  logic                  i_unsigned,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic                  o_dc_req,
    output logic                  o_dc_we,
    output logic [ADDR_WIDTH-1:0] o_dc_addr,
    output logic [3:0]            o_dc_wstrb,
    output logic [31:0]           o_dc_wdata,
    input  logic                  i_dc_ready,
    input  logic                  i_dc_rvalid,
    input  logic [31:0]           i_dc_rdata,
    output logic [31:0]           o_rdata,
    output logic                  o_rdata_valid,
    output logic                  o_stall,
    output logic                  o_misaligned,
    output logic                  o_bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    // WAIT exits on the cycle the counter would reach WAIT_LIMIT
    localparam logic [7:0] LAST_CNT = 8'(WAIT_LIMIT - 1);

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt;
    logic        cap_b, cap_h, cap_u;
    logic [1:0]  cap_off;
    logic        is_b, is_h, op_start, misaligned, start_ok;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata, ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        is_b       = i_ls_b;
        is_h       = i_ls_h & ~i_ls_b;
        op_start   = (i_memread | i_memwrite) && (state == S_IDLE);
        misaligned = (is_h & i_addr[0]) | (~is_b & ~is_h & (i_addr[1:0] != 2'b00));
        start_ok   = op_start & ~misaligned;
        o_stall    = ~i_rst & (start_ok | (state == S_REQ) | (state == S_WAIT));
    end

    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = i_wdata;
        if (is_b) begin
            st_wstrb = 4'b0001 << i_addr[1:0];
            st_wdata = {4{i_wdata[7:0]}};
        end else if (is_h) begin
            st_wstrb = i_addr[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{i_wdata[15:0]}};
        end
        if (!i_memwrite) st_wstrb = 4'b0000;
    end

    always_comb begin
        ld_byte = i_dc_rdata[{cap_off, 3'b000} +: 8];
        ld_half = i_dc_rdata[{cap_off[1], 4'b0000} +: 16];
        if (cap_b)      ld_data = {{24{ld_byte[7] & ~cap_u}}, ld_byte};
        else if (cap_h) ld_data = {{16{ld_half[15] & ~cap_u}}, ld_half};
        else            ld_data = i_dc_rdata;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_REQ;
            S_REQ:   if (i_dc_ready) state_nxt = S_WAIT;
            S_WAIT:  if (i_dc_rvalid || wait_cnt == LAST_CNT) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wait_cnt      <= 8'd0;
            o_dc_req      <= 1'b0;
            o_dc_we       <= 1'b0;
            o_dc_addr     <= '0;
            o_dc_wstrb    <= 4'b0000;
            o_dc_wdata    <= 32'd0;
            o_rdata       <= 32'd0;
            o_rdata_valid <= 1'b0;
            o_misaligned  <= 1'b0;
            o_bus_err     <= 1'b0;
            cap_b         <= 1'b0;
            cap_h         <= 1'b0;
            cap_u         <= 1'b0;
            cap_off       <= 2'b00;
        end else begin
            o_rdata_valid <= 1'b0;
            o_misaligned  <= 1'b0;
            o_bus_err     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op_start && misaligned) begin
                        o_misaligned <= 1'b1;
                    end else if (start_ok) begin
                        o_dc_req   <= 1'b1;
                        o_dc_we    <= i_memwrite;
                        o_dc_addr  <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
                        o_dc_wstrb <= st_wstrb;
                        o_dc_wdata <= st_wdata;
                        cap_b      <= is_b;
                        cap_h      <= is_h;
                        cap_u      <= i_unsigned;
                        cap_off    <= i_addr[1:0];
                    end
                end
                S_REQ: begin
                    if (i_dc_ready) begin
                        o_dc_req <= 1'b0;
                        wait_cnt <= 8'd0;
                    end
                end
                S_WAIT: begin
                    // o_dc_we stays valid through the access, so it doubles as the store flag
                    if (i_dc_rvalid) begin
                        if (!o_dc_we) o_rdata <= ld_data;
                        o_rdata_valid <= ~o_dc_we;
                    end else if (wait_cnt == LAST_CNT) begin
                        o_bus_err     <= 1'b1;
                        o_rdata_valid <= ~o_dc_we;
                        if (!o_dc_we) o_rdata <= 32'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - randomized self-checking bench for lsu_mem_ctrl against a behavioural model
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        i_rst, i_memread, i_memwrite, i_ls_b, i_ls_h, i_unsigned;
    logic [31:0] i_addr, i_wdata, i_dc_rdata;
    logic        i_dc_ready, i_dc_rvalid;
    logic        o_dc_req, o_dc_we, o_rdata_valid, o_stall, o_misaligned, o_bus_err;
    logic [31:0] o_dc_addr, o_dc_wdata, o_rdata;
    logic [3:0]  o_dc_wstrb;

    int n_checks = 0;
    int n_fail   = 0;

    int          r_stall, r_req, r_valid, r_mis, r_err, r_after;
    logic [31:0] r_rdata, r_addr, r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_we, r_unstable, r_done;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.ADDR_WIDTH(32), .WAIT_LIMIT(8)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_memread(i_memread), .i_memwrite(i_memwrite),
        .i_ls_b(i_ls_b), .i_ls_h(i_ls_h), .i_unsigned(i_unsigned), .i_addr(i_addr),
        .i_wdata(i_wdata), .o_dc_req(o_dc_req), .o_dc_we(o_dc_we), .o_dc_addr(o_dc_addr),
        .o_dc_wstrb(o_dc_wstrb), .o_dc_wdata(o_dc_wdata), .i_dc_ready(i_dc_ready),
        .i_dc_rvalid(i_dc_rvalid), .i_dc_rdata(i_dc_rdata), .o_rdata(o_rdata),
        .o_rdata_valid(o_rdata_valid), .o_stall(o_stall), .o_misaligned(o_misaligned),
        .o_bus_err(o_bus_err)
    );

    function automatic int nbytes_of(input logic b, input logic h);
        return b ? 1 : (h ? 2 : 4);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [1:0] off,
                                             input int nb, input logic u);
        longint v, span;
        v    = rdata;
        v    = v >> (8 * off);
        span = 64'sd1 << (8 * nb);
        v    = v % span;
        if (!u && nb < 4 && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_wstrb(input logic wr, input int nb, input logic [1:0] off);
        int m;
        if (!wr) return 4'b0000;
        m = ((1 << nb) - 1) << off;
        return m[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input int nb);
        logic [31:0] o;
        for (int i = 0; i < 4; i++) o[8*i +: 8] = wd[8*(i % nb) +: 8];
        return o;
    endfunction

    task automatic run_op(input logic rd, input logic wr, input logic b, input logic h, input logic u,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                          input int rdelay, input int vdelay);
        bit hs, ready_now;
        int wcnt;
        r_stall = 0; r_req = 0; r_valid = 0; r_mis = 0; r_err = 0;
        r_unstable = 0; r_done = 0; hs = 0; wcnt = 0;
        i_memread = rd; i_memwrite = wr; i_ls_b = b; i_ls_h = h; i_unsigned = u;
        i_addr = addr; i_wdata = wdata; i_dc_rdata = rdata;
        for (int cyc = 0; cyc < 60 && !r_done; cyc++) begin
            #1;
            if (o_stall) r_stall++;
            if (o_rdata_valid) begin r_valid++; r_rdata = o_rdata; end
            if (o_misaligned) r_mis++;
            if (o_bus_err) r_err++;
            ready_now = 0;
            if (o_dc_req) begin
                if (r_req == 0) begin
                    r_addr = o_dc_addr; r_wstrb = o_dc_wstrb; r_wdata = o_dc_wdata; r_we = o_dc_we;
                end else if ({o_dc_addr, o_dc_wstrb, o_dc_wdata, o_dc_we} !== {r_addr, r_wstrb, r_wdata, r_we}) begin
                    r_unstable = 1;
                end
                ready_now = (r_req == rdelay);
                r_req++;
            end
            i_dc_ready  = ready_now;
            i_dc_rvalid = hs && vdelay >= 0 && wcnt == vdelay;
            if (hs) wcnt++;
            if (cyc > 0 && !o_stall) begin
                r_done = 1; i_memread = 0; i_memwrite = 0; i_dc_ready = 0; i_dc_rvalid = 0;
            end
            @(posedge clk); #1;
            if (ready_now) hs = 1;
        end
        i_memread = 0; i_memwrite = 0; i_dc_ready = 0; i_dc_rvalid = 0;
        n_checks++;
        if (!r_done) begin n_fail++; $display("FAIL op_bound: stall never released (got %0d stall cycles, required completion within 60)", r_stall); end
        #1;
        r_after = int'(o_rdata_valid) + int'(o_misaligned) + int'(o_bus_err);
    endtask

    task automatic test_reset;
        i_rst = 1; i_memread = 1; i_addr = 32'h100; i_ls_b = 0; i_ls_h = 0;
        @(posedge clk); #1;
        n_checks++;
        if (o_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b required 0", o_stall); end
        @(posedge clk); #1;
        n_checks++;
        if ({o_dc_req, o_dc_we, o_dc_addr, o_dc_wstrb, o_dc_wdata, o_rdata, o_rdata_valid, o_misaligned, o_bus_err} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got req=%b addr=%h rdata=%h not all zero, required all 0", o_dc_req, o_dc_addr, o_rdata);
        end
        i_memread = 0; i_rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_lb;
        run_op(1, 0, 1, 0, 0, 32'h1003, 32'h0, 32'h80FF_1234, 0, 0);
        n_checks++; if (r_addr !== 32'h1000) begin n_fail++; $display("FAIL lb_addr: got %h required 00001000", r_addr); end
        n_checks++; if (r_wstrb !== 4'b0000 || r_we !== 1'b0) begin n_fail++; $display("FAIL lb_wstrb: got %b/we=%b required 0000/0", r_wstrb, r_we); end
        n_checks++; if (r_stall != 3) begin n_fail++; $display("FAIL lb_stall: got %0d required 3", r_stall); end
        n_checks++; if (r_valid != 1 || r_rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata: got %h (%0d pulses) required ffffff80 (1)", r_rdata, r_valid); end
        n_checks++; if (r_after != 0) begin n_fail++; $display("FAIL lb_pulse_width: got %0d pulses after DONE required 0", r_after); end
    endtask

    task automatic test_lh_lhu;
        run_op(1, 0, 0, 1, 1, 32'h2002, 32'h0, 32'h9ABC_0000, 0, 0);
        n_checks++; if (r_rdata !== 32'h0000_9ABC) begin n_fail++; $display("FAIL lhu_rdata: got %h required 00009abc", r_rdata); end
        run_op(1, 0, 0, 1, 0, 32'h2002, 32'h0, 32'h9ABC_0000, 0, 0);
        n_checks++; if (r_rdata !== 32'hFFFF_9ABC) begin n_fail++; $display("FAIL lh_rdata: got %h required ffff9abc", r_rdata); end
    endtask

    task automatic test_sb_delayed;
        run_op(0, 1, 1, 0, 0, 32'h3001, 32'h0000_00A5, 32'h0, 4, 0);
        n_checks++; if (r_req != 5 || r_unstable) begin n_fail++; $display("FAIL sb_req_hold: got %0d cycles unstable=%b required 5 stable", r_req, r_unstable); end
        n_checks++; if (r_wstrb !== 4'b0010 || r_wdata !== 32'hA5A5_A5A5 || r_we !== 1'b1 || r_addr !== 32'h3000) begin
            n_fail++; $display("FAIL sb_fields: got wstrb=%b wdata=%h we=%b addr=%h required 0010 a5a5a5a5 1 00003000", r_wstrb, r_wdata, r_we, r_addr); end
        n_checks++; if (r_stall != 7 || r_valid != 0) begin n_fail++; $display("FAIL sb_stall: got stall=%0d valid=%0d required 7 0", r_stall, r_valid); end
    endtask

    task automatic test_misaligned;
        run_op(0, 1, 0, 1, 0, 32'h4001, 32'h1234, 32'h0, 0, 0);
        n_checks++; if (r_mis != 1 || r_req != 0 || r_stall != 0) begin n_fail++; $display("FAIL sh_misaligned: got mis=%0d req=%0d stall=%0d required 1 0 0", r_mis, r_req, r_stall); end
        run_op(1, 0, 0, 0, 0, 32'h4002, 32'h0, 32'h0, 0, 0);
        n_checks++; if (r_mis != 1 || r_req != 0 || r_stall != 0) begin n_fail++; $display("FAIL lw_misaligned: got mis=%0d req=%0d stall=%0d required 1 0 0", r_mis, r_req, r_stall); end
        n_checks++; if (r_after != 0) begin n_fail++; $display("FAIL misaligned_pulse_width: got %0d required 0", r_after); end
    endtask

    task automatic test_timeout;
        run_op(1, 0, 0, 0, 0, 32'h6000, 32'h0, 32'h5555_AAAA, 0, -1);
        n_checks++; if (r_err != 1 || r_valid != 1) begin n_fail++; $display("FAIL timeout_pulses: got err=%0d valid=%0d required 1 1", r_err, r_valid); end
        n_checks++; if (r_rdata !== 32'h0) begin n_fail++; $display("FAIL timeout_rdata: got %h required 00000000", r_rdata); end
        n_checks++; if (r_stall != 10) begin n_fail++; $display("FAIL timeout_stall: got %0d required 10", r_stall); end
    endtask

    task automatic test_reset_mid_op;
        i_memread = 1; i_ls_b = 0; i_ls_h = 0; i_unsigned = 0; i_addr = 32'h5000;
        #1;
        @(posedge clk); #1;
        i_dc_ready = o_dc_req;
        @(posedge clk); #1;
        i_dc_ready = 0; i_rst = 1;
        #1;
        n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL midrst_stall: got %b required 0", o_stall); end
        @(posedge clk); #1;
        n_checks++;
        if ({o_dc_req, o_dc_we, o_dc_addr, o_dc_wstrb, o_dc_wdata, o_rdata, o_rdata_valid, o_misaligned, o_bus_err} !== '0) begin
            n_fail++; $display("FAIL midrst_outputs: got req=%b addr=%h rdata=%h required all 0", o_dc_req, o_dc_addr, o_rdata); end
        i_rst = 0; i_memread = 0; i_dc_rvalid = 1; i_dc_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        i_dc_rvalid = 0;
        n_checks++; if (o_rdata_valid !== 1'b0 || o_rdata !== 32'h0 || o_stall !== 1'b0) begin
            n_fail++; $display("FAIL midrst_late_rvalid: got valid=%b rdata=%h stall=%b required 0 0 0", o_rdata_valid, o_rdata, o_stall); end
        run_op(1, 0, 0, 0, 0, 32'h5004, 32'h0, 32'h1357_9BDF, 1, 2);
        n_checks++; if (r_valid != 1 || r_rdata !== 32'h1357_9BDF || r_stall != 6) begin
            n_fail++; $display("FAIL midrst_next_lw: got rdata=%h valid=%0d stall=%0d required 13579bdf 1 6", r_rdata, r_valid, r_stall); end
    endtask

    task automatic test_random;
        logic rd, wr, b, h, u, is_ld, mis;
        logic [31:0] addr, wd, rdv;
        int rdl, vdl, nb, kind;
        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 2);
            rd = (kind != 1); wr = (kind != 0);
            nb = $urandom_range(0, 2);
            b = (nb == 0); h = (nb == 1); u = $urandom_range(0, 1);
            addr = $urandom;
            if ($urandom_range(0, 1)) addr[1:0] = 2'b00;
            wd = $urandom; rdv = $urandom;
            rdl = $urandom_range(0, 3); vdl = $urandom_range(0, 4);
            nb = nbytes_of(b, h);
            is_ld = !wr;
            mis = (addr % nb) != 0;
            run_op(rd, wr, b, h, u, addr, wd, rdv, rdl, vdl);
            n_checks++;
            if (mis) begin
                if (r_mis != 1 || r_req != 0 || r_stall != 0) begin n_fail++;
                    $display("FAIL rand_mis[%0d]: got mis=%0d req=%0d stall=%0d required 1 0 0", k, r_mis, r_req, r_stall); end
            end else begin
                if (r_mis != 0 || r_addr !== {addr[31:2], 2'b00} || r_we !== wr || r_wstrb !== ref_wstrb(wr, nb, addr[1:0])
                    || r_unstable || r_stall != 3 + rdl + vdl || r_err != 0 || r_valid != int'(is_ld)) begin
                    n_fail++;
                    $display("FAIL rand_req[%0d]: got addr=%h we=%b wstrb=%b stall=%0d valid=%0d required %h %b %b %0d %0d",
                             k, r_addr, r_we, r_wstrb, r_stall, r_valid, {addr[31:2], 2'b00}, wr,
                             ref_wstrb(wr, nb, addr[1:0]), 3 + rdl + vdl, int'(is_ld));
                end
                n_checks++;
                if (wr && r_wdata !== ref_wdata(wd, nb)) begin n_fail++;
                    $display("FAIL rand_wdata[%0d]: got %h required %h", k, r_wdata, ref_wdata(wd, nb)); end
                if (is_ld && r_rdata !== ref_load(rdv, addr[1:0], nb, u)) begin n_fail++;
                    $display("FAIL rand_rdata[%0d]: got %h required %h", k, r_rdata, ref_load(rdv, addr[1:0], nb, u)); end
            end
            n_checks++;
            if (r_after != 0) begin n_fail++; $display("FAIL rand_pulse_width[%0d]: got %0d required 0", k, r_after); end
        end
    endtask

    initial begin
        i_rst = 1; i_memread = 0; i_memwrite = 0; i_ls_b = 0; i_ls_h = 0; i_unsigned = 0;
        i_addr = 0; i_wdata = 0; i_dc_rdata = 0; i_dc_ready = 0; i_dc_rvalid = 0;
        test_reset;
        test_lb;
        test_lh_lhu;
        test_sb_delayed;
        test_misaligned;
        test_timeout;
        test_reset_mid_op;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Memory-stage load/store unit that consumes the decoded memory controls (memread, memwrite, ls_b, ls_h, unsigned) and executes the access against the data cache.
- Uses a valid/ready request and response handshake toward the dcache.
- Returns sign- or zero-extended load data to writeback.
- Drives the pipeline stall that feeds back into the control decoder's i_stall.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- WAIT_LIMIT, 255, maximum cycles in WAIT before a bus error is flagged (8-bit counter; must be ≤255).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_memread  in  1  load in MEM stage
- i_memwrite  in  1  store in MEM stage
- i_ls_b  in  1  byte access
- i_ls_h  in  1  halfword access (neither b nor h = word)
- i_unsigned  in  1  zero-extend load
- i_addr  in  ADDR_WIDTH  byte address from ALU
- i_wdata  in  32  store data (rs2)
- o_dc_req  out  1  request valid
- o_dc_we  out  1  1 = write
- o_dc_addr  out  ADDR_WIDTH  word-aligned address ({addr[ADDR_WIDTH-1:2],2'b00})
- o_dc_wstrb  out  4  byte enables
- o_dc_wdata  out  32  lane-replicated store data
- i_dc_ready  in  1  cache accepts request
- i_dc_rvalid  in  1  response/ack (loads and stores)
- i_dc_rdata  in  32  load word
- o_rdata  out  32  extended load result
- o_rdata_valid  out  1  one-cycle pulse, load complete
- o_stall  out  1  hold pipeline
- o_misaligned  out  1  one-cycle pulse, misaligned access
- o_bus_err  out  1  one-cycle pulse, response timeout

Behaviour:
- Reset (synchronous, i_rst=1 at posedge):
  - State goes to IDLE; wait counter clears to 0.
  - All registered outputs reset to 0: o_dc_req, o_dc_we, o_dc_addr, o_dc_wstrb, o_dc_wdata, o_rdata, o_rdata_valid, o_misaligned, o_bus_err.
  - o_stall is 0 while i_rst=1.
- States:
  - IDLE, REQ, WAIT, DONE.
- op_start = (i_memread | i_memwrite) in IDLE.
  - Simultaneous memread and memwrite is treated as a store.
- Misalignment:
  - Defined as halfword with addr[0]=1, or word with addr[1:0]≠0.
  - In IDLE with op_start and misaligned: no cache request, o_misaligned=1 next cycle, o_stall stays 0, state stays IDLE.
- Aligned start (IDLE):
  - o_stall=1 combinationally in the same cycle.
  - Capture addr, we, size, unsigned, offset=addr[1:0], wstrb and wdata; go to REQ.
- REQ:
  - o_dc_req=1; all request fields held stable until i_dc_ready=1.
  - On handshake: drop o_dc_req, clear counter, go to WAIT.
- WAIT:
  - Count cycles.
  - On i_dc_rvalid: capture extended data into o_rdata for loads, go to DONE.
  - If the counter reaches WAIT_LIMIT without rvalid: o_bus_err=1 and go to DONE; o_rdata=0 for loads in this case.
  - i_dc_rvalid outside WAIT is ignored.
- DONE:
  - o_stall=0; o_rdata_valid=1 only for loads (including the timeout case).
  - Unconditionally return to IDLE; no new op is started in DONE. The pipeline advances at the end of DONE.
- o_stall = (IDLE & op_start & aligned) | REQ | WAIT.
- Stall latency: an aligned access with ready and rvalid each in the first possible cycle stalls for 3 cycles (start, REQ, WAIT), then DONE.
- Store strobes and data:
  - sb: wstrb = 4'b0001 << offset; wdata = {4{wdata[7:0]}}.
  - sh: wstrb = offset[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - sw: wstrb = 4'b1111; wdata = wdata.
  - For loads: wstrb = 0 and o_dc_we = 0.
- Load extraction:
  - Byte: rdata[8*offset +: 8].
  - Half: rdata[16*offset[1] +: 16].
  - Sign-extended unless the captured unsigned flag is set; word is passed through.
- Reset mid-operation: abort immediately (req drops the same edge) and return to IDLE; a late i_dc_rvalid is ignored.
- Pulse outputs (o_rdata_valid, o_misaligned, o_bus_err) are high for exactly one cycle.

Test Plan:
- lb, addr=0x1003, rdata=0x80FF_1234, ready/rvalid immediate → wstrb=0, o_dc_addr=0x1000, stall high 3 cycles, o_rdata=0xFFFF_FF80, o_rdata_valid pulse.
- lhu, addr=0x2002, rdata=0x9ABC_0000 → o_rdata=0x0000_9ABC; lh with the same stimulus → 0xFFFF_9ABC.
- sb, addr=0x3001, wdata=0x0000_00A5, ready delayed 4 cycles → o_dc_req/addr/wstrb=0010/wdata=0xA5A5_A5A5 held stable 5 cycles, stall until DONE, no o_rdata_valid.
- sh at addr=0x4001 and lw at addr=0x4002 → o_misaligned pulse, o_dc_req never asserted, o_stall never asserted.
- lw with i_dc_rvalid never returning, WAIT_LIMIT=8 → o_bus_err pulse after 8 WAIT cycles, o_rdata=0, o_rdata_valid pulse, stall released.
- lw in WAIT, i_rst for 1 cycle, then i_dc_rvalid=1 → all outputs 0, state IDLE, rvalid ignored, next lw completes normally.
